// File: rtl/risc_disp_pkg.sv
// ============================================================================
// Module      : risc_disp_pkg
// Description : Shared types and constants for the hex display driver: digit
//               count, scan state encoding, blank pattern and hex-to-segment
//               table (active-low, bit order {g,f,e,d,c,b,a}).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package risc_disp_pkg;

    localparam int NDIG = 4;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational 4-bit hex digit to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hex_to_seg
    import risc_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

`default_nettype wire

// File: rtl/risc_hex_display.sv
// ============================================================================
// Module      : risc_hex_display
// Description : Debounces the processor's 16-bit observation value r (a value
//               must be stable for HOLD_CYCLES clocks before it is shown) and
//               scans it as four hex digits onto an active-low multiplexed
//               7-segment display, with a blank gap before every digit. The
//               decimal point on digit 0 flags a freshly updated value for
//               the remainder of the frame.
//               Optional macro LZ_BLANK_EN: leading-zero digits stay dark.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module risc_hex_display
    import risc_disp_pkg::*;
#(
    parameter int DIGIT_CYC   = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] r,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [15:0] shown,
    output logic        upd
);

    localparam int c_TIMER_W = $clog2(max_int(DIGIT_CYC, BLANK_CYC) + 1);
    localparam int c_CNT_W   = $clog2(HOLD_CYCLES + 1);
    localparam int c_DIG_W   = $clog2(NDIG);

    localparam logic [c_TIMER_W-1:0] c_BLANK_LAST = c_TIMER_W'(BLANK_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_DRIVE_LAST = c_TIMER_W'(DIGIT_CYC - 1);
    localparam logic [c_CNT_W-1:0]   c_HOLD       = c_CNT_W'(HOLD_CYCLES);
    localparam logic [c_DIG_W-1:0]   c_DIG_LAST   = c_DIG_W'(NDIG - 1);

    // Stability filter
    logic [15:0]          r_cand;
    logic [c_CNT_W-1:0]   r_cnt;

    // Scanner
    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_TIMER_W-1:0] w_timer_nxt;
    logic [c_DIG_W-1:0]   r_dig;
    logic [c_DIG_W-1:0]   w_dig_nxt;
    logic [3:0]           r_dig_val;
    logic [3:0]           w_dig_val_nxt;
    logic [3:0]           w_nibble;
    logic [6:0]           w_seg_pat;
    logic                 w_dark;

    // Freshness
    logic                 r_fresh;
    logic                 w_fresh_nxt;
    logic                 w_fresh_clr;

    // Registered output next-values
    logic [3:0]           w_an_nxt;
    logic [6:0]           w_seg_nxt;
    logic                 w_dp_n_nxt;

    assign w_nibble = shown[{r_dig, 2'b00} +: 4];

    // Track candidate value and how long it has been stable; publish it once held long enough
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_cand <= '0;
            r_cnt  <= '0;
            shown  <= '0;
            upd    <= 1'b0;
        end else begin
            if (r != r_cand) begin
                r_cand <= r;
                r_cnt  <= c_CNT_W'(1);
            end else if (r_cnt != c_HOLD) begin
                r_cnt  <= r_cnt + c_CNT_W'(1);
            end

            if ((r_cnt == c_HOLD) && (r_cand != shown)) begin
                shown <= r_cand;
                upd   <= 1'b1;
            end else begin
                upd   <= 1'b0;
            end
        end
    end

    // Scan sequencing: blank gap, then drive one digit; digit value is frozen on entry to DRIVE
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer + c_TIMER_W'(1);
        w_dig_nxt     = r_dig;
        w_dig_val_nxt = r_dig_val;
        w_fresh_clr   = 1'b0;
        case (r_state)
            BLANK: begin
                if (r_timer == c_BLANK_LAST) begin
                    w_state_nxt   = DRIVE;
                    w_timer_nxt   = '0;
                    w_dig_val_nxt = w_nibble;
                end
            end
            DRIVE: begin
                if (r_timer == c_DRIVE_LAST) begin
                    w_state_nxt = BLANK;
                    w_timer_nxt = '0;
                    w_dig_nxt   = (r_dig == c_DIG_LAST) ? '0 : r_dig + c_DIG_W'(1);
                    w_fresh_clr = (r_dig == c_DIG_LAST);
                end
            end
            default: begin
                w_state_nxt = BLANK;
                w_timer_nxt = '0;
            end
        endcase
        // A new value arriving on the frame's final clock must still be flagged.
        if (upd) begin
            w_fresh_nxt = 1'b1;
        end else if (w_fresh_clr) begin
            w_fresh_nxt = 1'b0;
        end else begin
            w_fresh_nxt = r_fresh;
        end
    end

`ifdef LZ_BLANK_EN
    logic r_dark;
    logic w_dark_nxt;

    // Decide leading-zero darkness once per digit, from the same snapshot as the digit value
    always_comb begin
        w_dark_nxt = r_dark;
        if ((r_state == BLANK) && (w_state_nxt == DRIVE)) begin
            w_dark_nxt = (r_dig != '0) && ((shown >> {r_dig, 2'b00}) == 16'h0000);
        end
    end

    // Hold the darkness decision for the duration of the digit
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_dark <= 1'b0;
        end else begin
            r_dark <= w_dark_nxt;
        end
    end

    assign w_dark = w_dark_nxt;
`else
    assign w_dark = 1'b0;
`endif

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_dig_val_nxt),
        .o_seg    (w_seg_pat)
    );

    // Decode display pins from the upcoming state so the registered outputs line up with it
    always_comb begin
        w_an_nxt   = 4'hF;
        w_seg_nxt  = SEG_BLANK;
        w_dp_n_nxt = 1'b1;
        if (w_state_nxt == DRIVE) begin
            w_an_nxt   = w_dark ? 4'hF : ~(4'b0001 << w_dig_nxt);
            w_seg_nxt  = w_seg_pat;
            w_dp_n_nxt = !((w_dig_nxt == '0) && w_fresh_nxt);
        end
    end

    // Scanner, freshness and display output registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state   <= BLANK;
            r_timer   <= '0;
            r_dig     <= '0;
            r_dig_val <= '0;
            r_fresh   <= 1'b0;
            an        <= 4'hF;
            seg       <= SEG_BLANK;
            dp_n      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_dig     <= w_dig_nxt;
            r_dig_val <= w_dig_val_nxt;
            r_fresh   <= w_fresh_nxt;
            an        <= w_an_nxt;
            seg       <= w_seg_nxt;
            dp_n      <= w_dp_n_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_risc_hex_display.sv
// ============================================================================
// Module      : tb_risc_hex_display
// Description : Scoreboard bench for risc_hex_display. The stimulus process
//               queues the expected digit windows and update pulses; monitor
//               processes compare whenever the display starts a digit or
//               pulses upd. Honours LZ_BLANK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_risc_hex_display;

    localparam int DIGIT_CYC   = 4;
    localparam int BLANK_CYC   = 2;
    localparam int HOLD_CYCLES = 3;
    localparam int FRAME_SLOT  = DIGIT_CYC + BLANK_CYC;

`ifdef LZ_BLANK_EN
    localparam bit c_LZ = 1'b1;
`else
    localparam bit c_LZ = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic [15:0] r     = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic [15:0] shown;
    logic        upd;

    int total = 0;
    int bad   = 0;
    int cyc;

    logic [11:0] q_win[$];
    int          q_upd_cyc[$];
    logic [15:0] q_upd_val[$];

    logic [3:0]  prev_an;
    logic [11:0] cur_win;
    int          gap;
    int          wlen;

    always #5 clock = ~clock;

    risc_hex_display #(
        .DIGIT_CYC   (DIGIT_CYC),
        .BLANK_CYC   (BLANK_CYC),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .r     (r),
        .an    (an),
        .seg   (seg),
        .dp_n  (dp_n),
        .shown (shown),
        .upd   (upd)
    );

    // Clock edges since the last reset release
    always @(posedge clock or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push_win(input int d, input logic [6:0] s, input logic dp, input bit dark);
        logic [3:0] a;
        a = ~(4'b0001 << d);
        if (!(c_LZ && dark)) q_win.push_back({a, s, dp});
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic dp0, input bit dk1, input bit dk2, input bit dk3);
        push_win(0, s0, dp0, 1'b0);
        push_win(1, s1, 1'b1, dk1);
        push_win(2, s2, 1'b1, dk2);
        push_win(3, s3, 1'b1, dk3);
    endtask

    task automatic push_upd(input int c, input logic [15:0] v);
        q_upd_cyc.push_back(c);
        q_upd_val.push_back(v);
    endtask

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Digit window and update-pulse monitor
    always @(negedge clock) begin
        if (!rst) begin
            prev_an = 4'hF;
            gap     = 0;
            wlen    = 0;
        end else begin
            if (an != 4'hF) begin
                if (prev_an == 4'hF) begin
                    chk("blank_gap", 32'(gap % FRAME_SLOT), 32'(BLANK_CYC));
                    cur_win = {an, seg, dp_n};
                    if (q_win.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL window: unexpected an=%b seg=%h dp_n=%b at cycle %0d",
                                 an, seg, dp_n, cyc);
                    end else begin
                        chk("window", 32'(cur_win), 32'(q_win.pop_front()));
                    end
                    wlen = 1;
                end else begin
                    chk("digit_hold", 32'({an, seg, dp_n}), 32'(cur_win));
                    wlen++;
                end
                gap = 0;
            end else begin
                if (prev_an != 4'hF) chk("digit_len", 32'(wlen), 32'(DIGIT_CYC));
                gap++;
            end
            prev_an = an;

            if (upd === 1'b1) begin
                if (q_upd_cyc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL upd: unexpected pulse at cycle %0d shown=%h", cyc, shown);
                end else begin
                    chk("upd_cycle", 32'(cyc), 32'(q_upd_cyc.pop_front()));
                    chk("upd_shown", 32'(shown), 32'(q_upd_val.pop_front()));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Stimulus and expected responses
    initial begin
        // Frame 0, value 0
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b1, 1'b1, 1'b1, 1'b1);
        // Frame 1, value 1234 freshly shown
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0, 1'b0, 1'b0);
        // Frames 2..4, 1234 held through the alternating noise
        for (int f = 2; f <= 4; f++)
            push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1'b1, 1'b0, 1'b0, 1'b0);
        // Frame 5, FFFF arrives mid digit 1
        push_frame(7'h19, 7'h30, 7'h0E, 7'h0E, 1'b1, 1'b0, 1'b0, 1'b0);
        // Frame 6, 0012 arrives mid digit 1
        push_frame(7'h0E, 7'h0E, 7'h40, 7'h40, 1'b1, 1'b0, 1'b1, 1'b1);
        // Frame 7, 0012
        push_frame(7'h24, 7'h79, 7'h40, 7'h40, 1'b1, 1'b0, 1'b1, 1'b1);
        // Frame 8 digit 0, interrupted by reset
        push_win(0, 7'h24, 1'b1, 1'b0);
        // After the second reset, value 0
        push_win(0, 7'h40, 1'b1, 1'b0);
        push_win(1, 7'h40, 1'b1, 1'b1);

        push_upd(25, 16'h1234);
        push_upd(129, 16'hFFFF);
        push_upd(153, 16'h0012);

        rst = 1'b0;
        r   = 16'h0000;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_an", 32'(an), 32'(4'hF));
        chk("reset_seg", 32'(seg), 32'(7'h7F));
        chk("reset_dp_n", 32'(dp_n), 32'(1'b1));
        chk("reset_shown", 32'(shown), 32'(16'h0000));
        chk("reset_upd", 32'(upd), 32'(1'b0));
        @(posedge clock);
        #1;
        rst = 1'b1;

        go_to(21);
        r = 16'h1234;

        for (int i = 0; i < 25; i++) begin
            go_to(47 + 2 * i);
            r = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
        end
        go_to(97);
        r = 16'h1234;
        go_to(103);
        chk("shown_after_noise", 32'(shown), 32'(16'h1234));

        go_to(125);
        r = 16'hFFFF;
        go_to(149);
        r = 16'h0012;

        go_to(195);
        rst = 1'b0;
        #2;
        chk("midreset_an", 32'(an), 32'(4'hF));
        chk("midreset_seg", 32'(seg), 32'(7'h7F));
        chk("midreset_dp_n", 32'(dp_n), 32'(1'b1));
        chk("midreset_shown", 32'(shown), 32'(16'h0000));
        chk("midreset_upd", 32'(upd), 32'(1'b0));
        r = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b1;

        go_to(13);
        chk("windows_consumed", 32'(q_win.size()), 32'(0));
        chk("upd_consumed", 32'(q_upd_cyc.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
